fir_coeff_bank: RTL and testbench

Double-buffered coefficient store that drives the `coeffs` array of the `fir` block directly upstream of it. Software or a control FSM writes new taps one at a time into a shadow bank, then issues a commit. The block copies the shadow bank into the active bank atomically, on a sample tick (`enable`), so the FIR never computes with a half-updated tap set. It also reports pending/settled status and a bank version count for the control plane.

---
 rtl/fir_pkg.sv | 18 +
 rtl/fir_coeff_shadow.sv | 47 ++++
 rtl/fir_coeff_bank.sv | 104 ++++++++++
 tb/tb_fir_coeff_bank.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared types and constants for the FIR coefficient store.
//   coeff_t      - signed coefficient word at the FIR datapath width
//   bank_state_t - commit/swap state of the coefficient bank
//   BANK_VER_W   - width of the completed-swap counter
package fir_pkg;

  localparam int FIR_BITWIDTH = 16;
  localparam int BANK_VER_W   = 8;

  typedef logic signed [FIR_BITWIDTH-1:0] coeff_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SETTLE  = 2'd2
  } bank_state_t;

endpackage

// File: rtl/fir_coeff_shadow.sv
// fir_coeff_shadow: N-entry shadow register file for FIR taps.
//   clk, rst : clock, synchronous active-high reset (clears all entries)
//   we       : write strobe, already qualified by the owner (state, range)
//   waddr    : write index
//   wdata    : signed tap value
//   raddr    : readback index; out-of-range indices read as zero
//   rdata    : registered readback, one-cycle latency, returns the pre-write
//              value on a same-cycle write/read of one address
//   bank     : whole shadow bank in parallel, feeds the active-bank swap
module fir_coeff_shadow
  import fir_pkg::*;
#(
  parameter int  BITWIDTH = 16,
  parameter int  N        = 16,
  localparam int AW       = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [AW-1:0]              waddr,
  input  logic signed [BITWIDTH-1:0] wdata,
  input  logic [AW-1:0]              raddr,
  output logic signed [BITWIDTH-1:0] rdata,
  output logic signed [BITWIDTH-1:0] bank [N]
);

  logic rd_in_range;

  // With a power-of-two depth every encodable index is a real entry.
  if (N == (1 << AW)) begin : g_rd_pow2
    assign rd_in_range = 1'b1;
  end else begin : g_rd_npow2
    localparam logic [AW:0] N_LIM = (AW+1)'(N);
    assign rd_in_range = ({1'b0, raddr} < N_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) bank[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) bank[waddr] <= wdata;
      rdata <= rd_in_range ? bank[raddr] : '0;
    end
  end

endmodule

// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: double-buffered coefficient store for the FIR block.
// Taps are written one at a time into a shadow bank; a commit copies the
// whole shadow bank into the active bank on a sample tick so the FIR never
// sees a half-updated tap set.
//   clk, rst : clock, synchronous active-high reset
//   enable   : FIR sample tick (same net as FIR enable)
//   wr_en, wr_addr, wr_data : shadow write port
//   rd_addr, rd_data        : shadow readback, registered
//   commit   : swap request, level sampled each cycle
//   coeffs   : active bank, drives FIR coeffs
//   pending  : a commit is waiting for a sample tick
//   settled  : FIR output fully reflects the active bank
//   wr_err   : one-cycle pulse after a rejected write
//   bank_ver : count of completed swaps, wraps at 255
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int  BITWIDTH = 16,
  parameter int  N        = 16,
  localparam int AW       = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic signed [BITWIDTH-1:0] wr_data,
  input  logic [AW-1:0]              rd_addr,
  output logic signed [BITWIDTH-1:0] rd_data,
  input  logic                       commit,
  output logic signed [BITWIDTH-1:0] coeffs [N],
  output logic                       pending,
  output logic                       settled,
  output logic                       wr_err,
  output logic [BANK_VER_W-1:0]      bank_ver
);

  bank_state_t                state;
  logic                       wr_in_range;
  logic                       wr_ok;
  logic signed [BITWIDTH-1:0] shadow_bank [N];

  if (N == (1 << AW)) begin : g_wr_pow2
    assign wr_in_range = 1'b1;
  end else begin : g_wr_npow2
    localparam logic [AW:0] N_LIM = (AW+1)'(N);
    assign wr_in_range = ({1'b0, wr_addr} < N_LIM);
  end

  // The committed set is frozen while a swap is outstanding.
  assign wr_ok = wr_en && wr_in_range && (state != PENDING);

  fir_coeff_shadow #(
    .BITWIDTH (BITWIDTH),
    .N        (N)
  ) u_shadow (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data),
    .bank  (shadow_bank)
  );

  // Status decodes come straight from the state register, so no input
  // reaches an output without passing a flop.
  assign pending = (state == PENDING);
  assign settled = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_err   <= 1'b0;
      bank_ver <= '0;
      for (int i = 0; i < N; i++) coeffs[i] <= '0;
    end else begin
      wr_err <= wr_en && !wr_ok;
      case (state)
        IDLE: begin
          if (commit) state <= PENDING;
        end
        PENDING: begin
          // Whole-bank copy on a single edge; a repeated commit here is
          // absorbed because we only leave on the sample tick.
          if (enable) begin
            coeffs   <= shadow_bank;
            bank_ver <= bank_ver + 1'b1;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          // One enabled tick lets the FIR product register catch up with
          // the new bank; a fresh commit abandons the wait.
          if (commit)      state <= PENDING;
          else if (enable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_bank.sv
module tb_fir_coeff_bank;
  import fir_pkg::*;

  localparam int BW = 16;
  localparam int NT = 16;
  localparam int S_RD = 0, S_PEND = 1, S_SETL = 2, S_ERR = 3, S_VER = 4, S_COEF = 5;

  logic                 clk = 1'b0;
  logic                 rst, enable, wr_en, commit;
  logic [3:0]           wr_addr, rd_addr;
  coeff_t               wr_data;
  logic signed [BW-1:0] rd_data;
  logic signed [BW-1:0] coeffs [NT];
  logic                 pending, settled, wr_err;
  logic [7:0]           bank_ver;

  fir_coeff_bank #(.BITWIDTH(BW), .N(NT)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .commit   (commit),
    .coeffs   (coeffs),
    .pending  (pending),
    .settled  (settled),
    .wr_err   (wr_err),
    .bank_ver (bank_ver)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    sel;
    int    idx;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int observe(int sel, int idx);
    logic signed [31:0] v;
    case (sel)
      S_RD:    v = rd_data;
      S_PEND:  v = {31'd0, pending};
      S_SETL:  v = {31'd0, settled};
      S_ERR:   v = {31'd0, wr_err};
      S_VER:   v = {24'd0, bank_ver};
      default: v = coeffs[idx];
    endcase
    return v;
  endfunction

  // Scoreboard monitor: on each falling edge, retire every expectation due
  // in this cycle; anything overdue counts as a miss.
  always @(negedge clk) begin
    int i;
    int a;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        a = observe(sb[i].sel, sb[i].idx);
        n_cmp++;
        if (a !== sb[i].val) begin
          n_bad++;
          $display("FAIL %s[%0d] @cyc %0d: got %0d, expected %0d",
                   sb[i].name, sb[i].idx, cyc, a, sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s[%0d]: check for cyc %0d missed", sb[i].name, sb[i].idx, sb[i].cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic expect_at(int dly, int sel, int idx, int val, string name);
    exp_t e;
    e.cyc = cyc + dly; e.sel = sel; e.idx = idx; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reset_state();
    expect_at(0, S_PEND, 0, 0, "rst_pending");
    expect_at(0, S_SETL, 0, 1, "rst_settled");
    expect_at(0, S_ERR,  0, 0, "rst_wr_err");
    expect_at(0, S_VER,  0, 0, "rst_bank_ver");
    expect_at(0, S_RD,   0, 0, "rst_rd_data");
    for (int i = 0; i < NT; i++) expect_at(0, S_COEF, i, 0, "rst_coeffs");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; wr_en = 1'b0; commit = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    tick(); tick();
    expect_reset_state();
    rst = 1'b0;

    // Load taps 0..15 with 1..16; active bank must stay zero.
    for (int i = 0; i < NT; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    rd_addr = 4'd5;
    expect_at(1, S_RD, 0, 6, "readback5");
    for (int i = 0; i < NT; i++) expect_at(1, S_COEF, i, 0, "coeffs_before_commit");
    tick();

    // Same-cycle write/read of one address returns the old value.
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'sd100; rd_addr = 4'd7;
    expect_at(1, S_RD, 0, 8, "rd_old_on_write");
    tick();
    wr_en = 1'b0;
    expect_at(1, S_RD, 0, 100, "rd_new_after_write");
    tick();

    // Commit with enable low for 10 cycles; rejected write mid-wait.
    commit = 1'b1;
    tick();
    commit = 1'b0;
    for (int k = 0; k < 10; k++) begin
      expect_at(0, S_PEND, 0, 1, "pending_hold");
      expect_at(0, S_SETL, 0, 0, "settled_low_pending");
      expect_at(0, S_COEF, 0, 0, "coeff0_frozen");
      expect_at(0, S_COEF, 15, 0, "coeff15_frozen");
      if (k == 4) begin
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'sd77;
        expect_at(1, S_ERR, 0, 1, "wr_err_pulse");
      end
      if (k == 5) begin
        wr_en = 1'b0;
        expect_at(1, S_ERR, 0, 0, "wr_err_one_cycle");
      end
      tick();
    end
    enable = 1'b1;
    for (int i = 0; i < NT; i++) expect_at(0, S_COEF, i, 0, "coeffs_pre_swap");
    expect_at(0, S_VER, 0, 0, "ver_pre_swap");
    tick();
    enable = 1'b0;
    for (int i = 0; i < NT; i++)
      expect_at(0, S_COEF, i, (i == 7) ? 100 : i + 1, "coeffs_post_swap");
    expect_at(0, S_VER,  0, 1, "ver_first_swap");
    expect_at(0, S_PEND, 0, 0, "pending_clear");
    expect_at(0, S_SETL, 0, 0, "settled_wait");
    tick();
    expect_at(0, S_SETL, 0, 0, "settled_wait_no_tick");
    enable = 1'b1;
    tick();
    expect_at(0, S_SETL, 0, 1, "settled_after_tick");
    enable = 1'b0;
    rd_addr = 4'd3;
    expect_at(1, S_RD, 0, 4, "shadow3_unchanged");
    tick();

    // Write and commit in the same IDLE cycle.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = -16'sd5; commit = 1'b1;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    expect_at(0, S_PEND, 0, 1, "pending_wr_commit");
    enable = 1'b1;
    tick();
    expect_at(0, S_COEF, 0, -5, "coeff0_same_cycle");
    expect_at(0, S_COEF, 1, 2, "coeff1_kept");
    expect_at(0, S_COEF, 7, 100, "coeff7_kept");
    expect_at(0, S_VER, 0, 2, "ver_second_swap");
    tick();
    expect_at(0, S_SETL, 0, 1, "settled_second");
    enable = 1'b0;

    // Swap repeatedly until the version counter wraps.
    for (int k = 0; k < 254; k++) begin
      commit = 1'b1;
      tick();
      commit = 1'b0; enable = 1'b1;
      tick();
      if (k == 252) expect_at(0, S_VER, 0, 255, "ver_255");
      tick();
      enable = 1'b0;
    end
    expect_at(0, S_VER, 0, 0, "ver_wrap");

    // Commit held high while PENDING: one increment only.
    commit = 1'b1;
    tick();
    tick();
    commit = 1'b0;
    expect_at(0, S_PEND, 0, 1, "pending_double_commit");
    enable = 1'b1;
    tick();
    expect_at(0, S_VER, 0, 1, "ver_single_inc");
    tick();
    tick();
    expect_at(0, S_VER, 0, 1, "ver_no_extra_inc");
    expect_at(0, S_SETL, 0, 1, "settled_double_commit");
    enable = 1'b0;

    // Commit during SETTLE restarts the pending wait.
    commit = 1'b1; enable = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    commit = 1'b1; enable = 1'b0;
    expect_at(0, S_SETL, 0, 0, "settle_state");
    tick();
    commit = 1'b0;
    expect_at(0, S_PEND, 0, 1, "settle_to_pending");
    expect_at(0, S_VER, 0, 2, "ver_before_resettle");
    enable = 1'b1;
    tick();
    expect_at(0, S_VER, 0, 3, "ver_after_resettle");
    tick();
    enable = 1'b0;
    expect_at(0, S_SETL, 0, 1, "settled_after_resettle");

    // Reset while PENDING discards the commit.
    commit = 1'b1;
    tick();
    commit = 1'b0;
    expect_at(0, S_PEND, 0, 1, "pending_before_rst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_reset_state();
    enable = 1'b1;
    tick();
    tick();
    expect_at(0, S_COEF, 0, 0, "no_swap_after_rst0");
    expect_at(0, S_COEF, 7, 0, "no_swap_after_rst7");
    expect_at(0, S_VER,  0, 0, "ver_after_rst");
    expect_at(0, S_PEND, 0, 0, "pending_after_rst");
    expect_at(0, S_SETL, 0, 1, "settled_after_rst");
    enable = 1'b0;
    rd_addr = 4'd5;
    expect_at(1, S_RD, 0, 0, "shadow_cleared");
    tick();

    // Drain outstanding expectations with a bounded wait.
    for (int k = 0; k < 5 && sb.size() > 0; k++) tick();
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations never checked", sb.size());
      n_cmp += sb.size();
      n_bad += sb.size();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
